wcoder_line_framer: RTL and testbench



---
 rtl/wcoder_line_framer.sv | 214 +++++++++++++++++++++
 tb/tb_wcoder_line_framer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wcoder_line_framer.sv
`timescale 1ns/1ps
// Line framer behind wcoder: buffers one line of coded bytes and, once the
// line closes, drains it as a packet: SYNC, line index, 16-bit length, payload.
module wcoder_line_framer #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned TAIL  = 4,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       href,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       err_ovf,
  output logic       err_drop
);

  localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (TAIL < 2) ? 1 : $clog2(TAIL + 1);

  typedef enum logic [2:0] {
    IDLE, FILL, TAILW, HDR_SYNC, HDR_IDX, HDR_LHI, HDR_LLO, PAYLOAD
  } state_t;

  state_t        state;
  logic          href_d;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_ptr;
  logic [TW-1:0] tail_cnt;
  logic [15:0]   len;
  logic [7:0]    line_idx;
  logic [7:0]    hdr_idx;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_q;

  logic          rise_c;
  logic          fall_c;
  logic          capture_c;
  logic          drain_c;
  logic          full_c;
  logic          xfer_c;
  logic          wr_en_c;
  logic [AW-1:0] wr_addr_c;
  logic [CW-1:0] wr_cnt_nxt_c;
  logic          last_c;
  logic          pop_c;
  logic [AW-1:0] rd_addr_c;

  // Edge detect, write qualification and read-ahead address.
  always_comb begin
    rise_c       = href && !href_d;
    fall_c       = !href && href_d;
    capture_c    = (state == FILL) || (state == TAILW);
    drain_c      = (state == HDR_SYNC) || (state == HDR_IDX) || (state == HDR_LHI) ||
                   (state == HDR_LLO) || (state == PAYLOAD);
    full_c       = (wr_cnt == CW'(DEPTH));
    xfer_c       = out_valid && out_ready;
    wr_en_c      = in_valid && !vsync &&
                   (((state == IDLE) && rise_c) || (capture_c && !full_c));
    wr_addr_c    = (state == IDLE) ? '0 : AW'(wr_cnt);
    wr_cnt_nxt_c = wr_en_c ? CW'(wr_cnt + CW'(1)) : wr_cnt;
    last_c       = (16'(rd_ptr) == len);
    pop_c        = xfer_c && (((state == HDR_LLO) && (len != 16'd0)) ||
                              ((state == PAYLOAD) && !last_c));
    rd_addr_c    = pop_c ? AW'(rd_ptr + CW'(1)) : AW'(rd_ptr);
  end

  // Line buffer; rd_q always tracks mem[rd_ptr] so payload streams back to back.
  always_ff @(posedge pclk) begin
    if (wr_en_c) begin
      mem[wr_addr_c] <= in_data;
    end
    rd_q <= mem[rd_addr_c];
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      href_d    <= 1'b0;
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      tail_cnt  <= '0;
      len       <= 16'd0;
      line_idx  <= 8'd0;
      hdr_idx   <= 8'd0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      busy      <= 1'b0;
      err_ovf   <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      href_d <= href;

      // Sticky errors; vsync clears them and restarts line numbering.
      if (vsync) begin
        line_idx <= 8'd0;
        err_ovf  <= 1'b0;
        err_drop <= 1'b0;
      end else begin
        if (capture_c && in_valid && full_c) begin
          err_ovf <= 1'b1;
        end
        if (drain_c && in_valid) begin
          err_drop <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (!vsync && rise_c) begin
            wr_cnt <= wr_en_c ? CW'(1) : '0;
            state  <= FILL;
          end
        end

        FILL: begin
          if (vsync) begin
            wr_cnt <= '0;
            state  <= IDLE;
          end else begin
            wr_cnt <= wr_cnt_nxt_c;
            if (fall_c) begin
              tail_cnt <= TW'(TAIL);
              state    <= TAILW;
            end
          end
        end

        TAILW: begin
          if (vsync) begin
            wr_cnt <= '0;
            state  <= IDLE;
          end else begin
            wr_cnt   <= wr_cnt_nxt_c;
            tail_cnt <= tail_cnt - TW'(1);
            // Close the line; a byte written on this cycle is counted.
            if (tail_cnt == TW'(1)) begin
              len       <= 16'(wr_cnt_nxt_c);
              hdr_idx   <= line_idx;
              rd_ptr    <= '0;
              out_data  <= SYNC;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= HDR_SYNC;
            end
          end
        end

        HDR_SYNC: begin
          if (xfer_c) begin
            out_data <= hdr_idx;
            state    <= HDR_IDX;
          end
        end

        HDR_IDX: begin
          if (xfer_c) begin
            out_data <= len[15:8];
            state    <= HDR_LHI;
          end
        end

        HDR_LHI: begin
          if (xfer_c) begin
            out_data <= len[7:0];
            state    <= HDR_LLO;
          end
        end

        HDR_LLO: begin
          if (xfer_c) begin
            if (len == 16'd0) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
              if (!vsync) begin
                line_idx <= line_idx + 8'd1;
              end
            end else begin
              out_data <= rd_q;
              rd_ptr   <= CW'(1);
              state    <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (xfer_c) begin
            if (last_c) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
              if (!vsync) begin
                line_idx <= line_idx + 8'd1;
              end
            end else begin
              out_data <= rd_q;
              rd_ptr   <= CW'(rd_ptr + CW'(1));
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wcoder_line_framer.sv
`timescale 1ns/1ps
// Randomized bench for wcoder_line_framer: a packet-level model predicts each
// framed line and a negedge monitor scores every handshake against it.
module tb_wcoder_line_framer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAIL  = 4;
  localparam logic [7:0]  SYNC  = 8'hA5;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       href;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       err_ovf;
  logic       err_drop;

  int         n_chk;
  int         n_pass;
  logic [7:0] exp_q[$];
  logic [7:0] data_q[$];
  logic [7:0] model_idx;
  logic       hold_pend;
  logic [7:0] hold_data;
  int         n;

  wcoder_line_framer #(.DEPTH(DEPTH), .TAIL(TAIL), .SYNC(SYNC)) dut (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err_ovf(err_ovf), .err_drop(err_drop)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Stream scoreboard plus hold-under-backpressure check.
  always @(negedge pclk) begin
    if (rst_n) begin
      if (hold_pend) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {24'd0, out_data}, {24'd0, hold_data});
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", {24'd0, out_data}, 32'h100);
        else check("stream", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic pulse_vsync();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    model_idx = 8'd0;
  endtask

  // Drives one line: href high hc cycles, then TAIL+1 cycles of acceptance window.
  task automatic drive_line(input int hc, input logic [63:0] vmask, input bit expect_pkt,
                            output int nacc);
    logic [7:0] acc[$];
    for (int c = 0; c <= hc + int'(TAIL); c++) begin
      href     = (c < hc);
      in_valid = vmask[c];
      if (vmask[c]) begin
        in_data = (data_q.size() > 0) ? data_q.pop_front() : 8'($urandom);
        if (acc.size() < DEPTH) acc.push_back(in_data);
      end else begin
        in_data = 8'($urandom);
      end
      if (expect_pkt && c == hc + int'(TAIL)) check("pre_close_valid", {31'd0, out_valid}, 32'd0);
      step();
    end
    href     = 1'b0;
    in_valid = 1'b0;
    nacc     = acc.size();
    if (expect_pkt) begin
      exp_q.push_back(SYNC);
      exp_q.push_back(model_idx);
      exp_q.push_back(8'(nacc >> 8));
      exp_q.push_back(8'(nacc));
      foreach (acc[i]) exp_q.push_back(acc[i]);
      check("first_valid", {31'd0, out_valid}, 32'd1);
      check("first_busy", {31'd0, busy}, 32'd1);
      check("first_sync", {24'd0, out_data}, {24'd0, SYNC});
    end
  endtask

  // mode 0: ready held high, 1: pattern 1,0,0 repeating, 2: random.
  task automatic wait_drain(input int mode, input int len);
    int cyc = 0;
    for (int i = 0; i < 400; i++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom);
      endcase
      step();
      cyc++;
      if (!busy) break;
    end
    out_ready = 1'b0;
    check("drain_busy", {31'd0, busy}, 32'd0);
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_empty", exp_q.size(), 32'd0);
    if (mode == 0) check("drain_cycles", cyc, len + 4);
    model_idx = model_idx + 8'd1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; model_idx = 8'd0; hold_pend = 1'b0; hold_data = 8'd0;
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    repeat (3) step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err_ovf", {31'd0, err_ovf}, 32'd0);
    check("rst_err_drop", {31'd0, err_drop}, 32'd0);
    rst_n = 1'b1;
    step();
    pulse_vsync();

    // Nominal line, then a second line carrying index 01.
    data_q = '{8'h11, 8'h22, 8'h33};
    drive_line(10, 64'hE, 1'b1, n);
    check("t1_len", n, 3);
    wait_drain(0, n);
    drive_line(3, 64'h3, 1'b1, n);
    wait_drain(2, n);

    // Tail byte two cycles after the fall, under 1,0,0 backpressure.
    data_q = '{8'h41, 8'h42, 8'h43, 8'h44};
    drive_line(5, 64'h8E, 1'b1, n);
    check("t2_len", n, 4);
    wait_drain(1, n);

    // Overflow: ten bytes into an eight-byte buffer.
    pulse_vsync();
    for (int i = 1; i <= 10; i++) data_q.push_back(8'(i));
    drive_line(12, 64'h3FF, 1'b1, n);
    check("t3_len", n, 8);
    wait_drain(0, n);
    check("ovf_set", {31'd0, err_ovf}, 32'd1);

    // A whole line arriving while the previous one is stalled is dropped.
    drive_line(4, 64'h7, 1'b1, n);
    out_ready = 1'b0;
    repeat (2) step();
    check("drop_clear", {31'd0, err_drop}, 32'd0);
    drive_line(7, 64'h3E, 1'b0, n);
    check("drop_set", {31'd0, err_drop}, 32'd1);
    check("drop_busy", {31'd0, busy}, 32'd1);
    check("ovf_sticky", {31'd0, err_ovf}, 32'd1);
    wait_drain(0, 3);
    repeat (TAIL + 3) begin
      step();
      check("no_ghost", {31'd0, out_valid}, 32'd0);
    end

    // vsync three bytes into line index 2: nothing emitted, flags cleared.
    href = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    pulse_vsync();
    repeat (3) step();
    href = 1'b0;
    repeat (TAIL + 4) begin
      step();
      check("vs_no_pkt", {31'd0, out_valid}, 32'd0);
    end
    check("vs_ovf_clr", {31'd0, err_ovf}, 32'd0);
    check("vs_drop_clr", {31'd0, err_drop}, 32'd0);
    drive_line(4, 64'h5, 1'b1, n);
    wait_drain(2, n);

    // vsync during a drain: packet keeps its index, next line is 01.
    drive_line(3, 64'h7, 1'b1, n);
    repeat (2) step();
    pulse_vsync();
    wait_drain(2, n);
    drive_line(2, 64'h1, 1'b1, n);
    wait_drain(2, n);

    // Randomized lines, including empty and overflowing ones.
    for (int t = 0; t < 24; t++) begin
      int hc;
      logic [63:0] vm;
      if ($urandom_range(0, 5) == 0) pulse_vsync();
      hc = $urandom_range(1, 10);
      vm = {$urandom, $urandom} & ((64'd1 << (hc + int'(TAIL) + 1)) - 64'd1);
      if ($urandom_range(0, 7) == 0) vm = 64'd0;
      drive_line(hc, vm, 1'b1, n);
      wait_drain(2, n);
      repeat ($urandom_range(1, 3)) step();
    end

    // Asynchronous reset in the middle of the payload.
    drive_line(8, 64'h3F, 1'b1, n);
    out_ready = 1'b1;
    repeat (6) step();
    check("mid_payload_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    model_idx = 8'd0;
    out_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    drive_line(3, 64'h6, 1'b1, n);
    wait_drain(0, n);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
